program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the program memory load port: accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions.
- Writes each instruction through the memory's wr_addr/wr_data/we port (we=2'b11 write strobe).
- Holds the processor in reset for the whole load and reports completion or error, verified by an XOR checksum.
- Sits between the host/UART byte interface and the program memory.

Parameters:
- START_ADDR, 8'h00, first program memory address written; later addresses increment mod 256.
- TIMEOUT, 16'd1000, idle cycles allowed without s_valid while a load is active before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts s_data this cycle; a transfer occurs when s_valid && s_ready.
- wr_addr  out  8  program memory write address.
- wr_data  out  16  program memory write data.
- we  out  2  2'b11 on a write cycle, else 2'b00.
- cpu_hold  out  1  high while busy; drives the processor reset.
- busy  out  1  load in progress.
- done  out  1  sticky: last load finished with a good checksum.
- err  out  1  sticky: last load had a bad checksum or timed out.

Behaviour:
- Single clock, synchronous active-high reset. On rst, outputs are s_ready=0, we=00, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, err=0, and the state is IDLE. Reset mid-load abandons the load immediately with no further writes.
- Stream format: LEN byte, then 2*N data bytes (high byte first per instruction), then CHK byte.
  - N = LEN, with LEN=0 meaning N=256.
  - CHK must equal the XOR of LEN and all data bytes.
- IDLE: s_ready=0.
  - start moves to LEN.
  - In the same edge: done and err clear, addr loads START_ADDR, chk_acc clears, busy and cpu_hold go high.
- LEN: s_ready=1. On a transfer: remaining <= N (9 bits), chk_acc ^= byte, go to HI.
- HI: s_ready=1. On a transfer: hi <= byte, chk_acc ^= byte, go to LO.
- LO: s_ready=1. On a transfer: wr_data <= {hi, byte}, wr_addr <= addr, chk_acc ^= byte, go to WRITE.
- WRITE (exactly one cycle):
  - we=11 and s_ready=0; wr_data and wr_addr are stable this cycle.
  - addr <= addr+1 (wraps 8'hFF to 8'h00) and remaining <= remaining-1.
  - Next state is CHK if remaining==1, else HI.
- CHK: s_ready=1. On a transfer, go to IDLE with busy=0 and cpu_hold=0.
  - done <= (byte == chk_acc).
  - err <= (byte != chk_acc).
- Write latency: we is asserted the cycle after the LO byte is accepted.
- Peak throughput: one instruction per 3 cycles.
- Back-pressure: with s_valid low, the state holds and nothing changes except the timeout counter.
- Timeout counter:
  - Resets on every transfer and on entry to LEN; increments while in LEN/HI/LO/CHK with s_valid=0.
  - When the count reaches TIMEOUT (TIMEOUT != 0), go to IDLE with err=1, done=0, busy=0, cpu_hold=0.
  - Writes already performed remain in memory.
- Writes are not rolled back on a checksum error; err tells the host to reload.
- start while busy is ignored.
- start and rst in the same cycle: rst wins.
- wr_addr and wr_data hold their last values outside WRITE; only we qualifies them.

Test Plan:
- Good load, START_ADDR=0: start, then bytes 02,12,34,AB,CD,42 with s_valid held high -> we=11 at addr 00 data 1234, then addr 01 data ABCD, each write 1 cycle after its LO byte; cpu_hold high from start until CHK accepted; done=1, err=0, busy=0.
- Bad checksum: same stream with CHK=43 -> both writes still occur; err=1, done=0, cpu_hold released.
- Wrap and back-pressure: START_ADDR=FE, stream 03,00,01,00,02,00,03,03 with s_valid low on alternate cycles -> writes at FE, FF, 00 with data 0001, 0002, 0003; s_ready=0 in WRITE cycles; done=1.
- LEN=00: 512 data bytes, all 0000 except the last instruction = 0x5A5A, CHK=00 -> exactly 256 writes covering addresses 00..FF in order; done=1.
- Timeout: TIMEOUT=10, start, send 02,12, then hold s_valid low -> err=1 on the 10th idle cycle, busy=0, no writes; a following start clears err.
- Reset mid-load: assert rst one cycle after the first LO byte is accepted (i.e., during WRITE) -> we=00 from the next cycle on, all outputs at reset values, the following stream bytes are ignored until a new start.

Source files
------------

// File: rtl/program_loader.sv
// Program memory loader: receives a LEN / instruction bytes / CHK stream and writes
// 16-bit instructions into program memory, holding the CPU in reset while it loads.
module program_loader #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [1:0]  we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CHK} state_t;

  state_t      state, state_next;
  logic [7:0]  addr;
  logic [7:0]  hi;
  logic [7:0]  chk_acc;
  logic [8:0]  remaining;
  logic [15:0] idle_cnt;
  logic        active;
  logic        xfer;
  logic        timed_out;

  always_comb begin
    active     = (state == LEN) || (state == HI) || (state == LO) || (state == CHK);
    s_ready    = active;
    xfer       = active && s_valid;
    timed_out  = active && !s_valid && (TIMEOUT != '0) && (idle_cnt == TIMEOUT - 16'd1);
    we         = (state == WRITE) ? 2'b11 : 2'b00;
    busy       = (state != IDLE);
    cpu_hold   = (state != IDLE);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LEN;
      LEN:     if (xfer) state_next = HI;
      HI:      if (xfer) state_next = LO;
      LO:      if (xfer) state_next = WRITE;
      WRITE:   state_next = (remaining == 9'd1) ? CHK : HI;
      CHK:     if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timed_out) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      hi        <= '0;
      chk_acc   <= '0;
      remaining <= '0;
      idle_cnt  <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          done     <= 1'b0;
          err      <= 1'b0;
          addr     <= START_ADDR;
          chk_acc  <= '0;
          idle_cnt <= '0;
        end
        LEN: if (xfer) begin
          // LEN=0 encodes a full 256-instruction image
          remaining <= (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
          chk_acc   <= chk_acc ^ s_data;
        end
        HI: if (xfer) begin
          hi      <= s_data;
          chk_acc <= chk_acc ^ s_data;
        end
        LO: if (xfer) begin
          wr_data <= {hi, s_data};
          wr_addr <= addr;
          chk_acc <= chk_acc ^ s_data;
        end
        WRITE: begin
          addr      <= addr + 8'd1;
          remaining <= remaining - 9'd1;
        end
        CHK: if (xfer) begin
          done <= (s_data == chk_acc);
          err  <= (s_data != chk_acc);
        end
        default: ;
      endcase

      if (active) begin
        if (xfer) begin
          idle_cnt <= '0;
        end else if (timed_out) begin
          idle_cnt <= '0;
          err      <= 1'b1;
          done     <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end

endmodule
